// File: rtl/crossover_engine.sv
`default_nettype none
// ============================================================================
// Module   : crossover_engine
// Brief    : Byte-segment single-point crossover with LFSR-chosen cut point.
//            Optional mutation enabled by defining CROSSOVER_MUTATION_EN.
// Revision : 1.0  initial release
// ============================================================================
module crossover_engine #(
  parameter int          GENE_WIDTH = 32,
  parameter int          SEG_W      = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GENE_WIDTH-1:0] parent_gene0,
  input  logic [GENE_WIDTH-1:0] parent_gene1,
  output logic [GENE_WIDTH-1:0] crossover_gene
);

  localparam int          N_SEG  = GENE_WIDTH / SEG_W;
  localparam int          K      = $clog2(N_SEG);
  localparam logic [15:0] c_seed = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0]           r_lfsr;
  logic                  w_fb;
  logic [K-1:0]          w_cut;
  logic [GENE_WIDTH-1:0] w_child;
  logic [GENE_WIDTH-1:0] w_result;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // A zero cut would copy parent1 whole; fold it onto the midpoint instead.
  assign w_cut = (r_lfsr[K-1:0] == '0) ? K'(N_SEG / 2) : r_lfsr[K-1:0];

  for (genvar i = 0; i < N_SEG; i++) begin : g_seg
    localparam logic [K:0] c_idx = (K+1)'(i);
    assign w_child[i*SEG_W +: SEG_W] = (c_idx < {1'b0, w_cut})
                                     ? parent_gene0[i*SEG_W +: SEG_W]
                                     : parent_gene1[i*SEG_W +: SEG_W];
  end

`ifdef CROSSOVER_MUTATION_EN
  logic [GENE_WIDTH-1:0] w_mut_mask;
  logic [31:0]           w_mut_idx;

  assign w_mut_idx  = 32'(r_lfsr[8:4]) % 32'(GENE_WIDTH);
  assign w_mut_mask = (r_lfsr[15:12] == 4'hF)
                    ? (GENE_WIDTH'(1) << w_mut_idx)
                    : '0;
  assign w_result   = w_child ^ w_mut_mask;
`else
  assign w_result   = w_child;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr         <= c_seed;
      crossover_gene <= '0;
    end else begin
      r_lfsr         <= {r_lfsr[14:0], w_fb};
      crossover_gene <= w_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crossover_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossover_engine
// Brief    : Self-checking bench for crossover_engine against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_crossover_engine;

  localparam int GW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [GW-1:0] p0  = '0;
  logic [GW-1:0] p1  = '0;
  logic [GW-1:0] child;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [15:0]   m_lfsr   = 16'hACE1;
  logic [15:0]   last_lfsr;
  logic [GW-1:0] exp_q;

  crossover_engine dut (
    .clk            (clk),
    .rst            (rst),
    .parent_gene0   (p0),
    .parent_gene1   (p1),
    .crossover_gene (child)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int v, fb;
    v  = int'(l);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 16'hFFFF);
  endfunction

  function automatic logic [GW-1:0] model_child(input logic [15:0] l,
                                                input logic [GW-1:0] a,
                                                input logic [GW-1:0] b);
    int          c;
    logic [63:0] mask;
    logic [GW-1:0] r;
    c = int'(l) % 4;
    if (c == 0) c = 2;
    mask = (64'd1 << (8 * c)) - 64'd1;
    r = (a & mask[GW-1:0]) | (b & ~mask[GW-1:0]);
`ifdef CROSSOVER_MUTATION_EN
    if (((int'(l) >> 12) & 15) == 15)
      r = r ^ (GW'(1) << (((int'(l) >> 4) & 31) % GW));
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [GW-1:0] obs,
                       input logic [GW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive on the falling edge, advance the model, sample 1ns after the rising edge.
  task automatic step(input logic r, input logic [GW-1:0] a, input logic [GW-1:0] b);
    @(negedge clk);
    rst = r; p0 = a; p1 = b;
    last_lfsr = m_lfsr;
    if (!r) begin
      exp_q  = '0;
      m_lfsr = 16'hACE1;
    end else begin
      exp_q  = model_child(m_lfsr, a, b);
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found_c0;

    // Reset held for two edges with arbitrary parents
    step(1'b0, 32'h12345678, 32'h9ABCDEF0);
    check("reset0", child, 32'h0);
    step(1'b0, 32'hFFFFFFFF, 32'h55555555);
    check("reset1", child, 32'h0);

    // First children after release
    step(1'b1, 32'h04030201, 32'h08070605);
    check("first", child, 32'h08070601);
    step(1'b1, 32'h04030201, 32'h08070605);
    check("second", child, 32'h08030201);
    step(1'b1, 32'h04030201, 32'h08070605);
    check("third", child, 32'h08030201);

    // Run until the cut field is zero and confirm the midpoint mapping
    found_c0 = 1'b0;
    for (int i = 0; i < 64 && !found_c0; i++) begin
      step(1'b1, 32'h04030201, 32'h08070605);
      check("fixed_model", child, exp_q);
      if (last_lfsr[1:0] == 2'b00 && last_lfsr[15:12] != 4'hF) begin
        check("c0_map", child, 32'h08070201);
        found_c0 = 1'b1;
      end
    end
    check("c0_found", {31'b0, found_c0}, 32'h1);

    // Random parents against the model
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, $urandom, $urandom);
      check("random", child, exp_q);
    end

    // Equal parents
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
`ifdef CROSSOVER_MUTATION_EN
      check("equal_model", child, exp_q);
`else
      check("equal", child, 32'hDEADBEEF);
`endif
    end

    // Mid-run reset restarts the identical sequence
    for (int i = 0; i < 37; i++) begin
      step(1'b1, $urandom, $urandom);
      check("prereset", child, exp_q);
    end
    step(1'b0, $urandom, $urandom);
    check("midreset", child, 32'h0);
    step(1'b1, 32'h04030201, 32'h08070605);
    check("rerun1", child, 32'h08070601);
    step(1'b1, 32'h04030201, 32'h08070605);
    check("rerun2", child, 32'h08030201);
    step(1'b1, 32'h04030201, 32'h08070605);
    check("rerun3", child, 32'h08030201);

    // Zero parents expose any mutation bit directly
    for (int i = 0; i < 4096; i++) begin
      step(1'b1, 32'h0, 32'h0);
      check("zero_model", child, exp_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
